// File: rtl/signed_fix_point_acc_requant_if.sv
// Handshake bundle between the multiplier array, the requantiser and the layer writeback path.
// The master drives requests and products; the slave (the requantiser) returns results.
interface signed_fix_point_acc_requant_if #(
    parameter int WIDTH     = 32,
    parameter int LEN_WIDTH = 16
);
    logic                   start;
    logic [LEN_WIDTH-1:0]   len;
    logic                   busy;
    logic                   in_valid;
    logic                   in_ready;
    logic [2*WIDTH-1:0]     in_prod;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic                   out_sat;

    modport master (
        output start, len, in_valid, in_prod, out_ready,
        input  busy, in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  start, len, in_valid, in_prod, out_ready,
        output busy, in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/signed_fix_point_acc_requant.sv
// Accumulates len double-width signed products, rounds half-up, drops POINT_WIDTH fraction bits
// and saturates to the WIDTH-bit working format; one result per dot product.
//
// state   | meaning
// S_IDLE  | waiting for start; accumulator cleared
// S_ACC   | taking products, counter tracks remaining terms
// S_ROUND | round, shift and saturate into the output register
// S_OUT   | result held until out_ready
module signed_fix_point_acc_requant #(
    parameter int WIDTH       = 32,
    parameter int POINT_WIDTH = 16,
    parameter int GUARD       = 8,
    parameter int LEN_WIDTH   = 16
) (
    input  logic clk,
    input  logic rst_n,
    signed_fix_point_acc_requant_if.slave bus
);
    localparam int AW = 2*WIDTH + GUARD;
    localparam logic signed [AW-1:0] R_MAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] R_MIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_ROUND, S_OUT} state_e;

    state_e                 state_q;
    logic [AW-1:0]          acc_q;
    logic [AW-1:0]          acc_d;
    logic [AW-1:0]          prod_ext;
    logic [AW-1:0]          rnd_sum;
    logic signed [AW-1:0]   r_shift;
    logic [LEN_WIDTH-1:0]   cnt_q;
    logic                   busy_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic                   out_sat_q;
    logic [WIDTH-1:0]       out_data_q;
    logic                   beat;

    assign prod_ext = {{GUARD{bus.in_prod[2*WIDTH-1]}}, bus.in_prod};
    assign acc_d    = acc_q + prod_ext;
    assign rnd_sum  = acc_q + (AW'(1) << (POINT_WIDTH-1));
    assign r_shift  = $signed(rnd_sum) >>> POINT_WIDTH;
    assign beat     = bus.in_valid && in_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        acc_q  <= '0;
                        cnt_q  <= bus.len;
                        busy_q <= 1'b1;
                        if (bus.len != '0) begin
                            state_q    <= S_ACC;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q <= S_ROUND;
                        end
                    end
                end
                S_ACC: begin
                    if (beat) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q - LEN_WIDTH'(1);
                        if (cnt_q == LEN_WIDTH'(1)) begin
                            state_q    <= S_ROUND;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                S_ROUND: begin
                    state_q     <= S_OUT;
                    out_valid_q <= 1'b1;
                    if (r_shift > R_MAX) begin
                        out_data_q <= {1'b0, {(WIDTH-1){1'b1}}};
                        out_sat_q  <= 1'b1;
                    end else if (r_shift < R_MIN) begin
                        out_data_q <= {1'b1, {(WIDTH-1){1'b0}}};
                        out_sat_q  <= 1'b1;
                    end else begin
                        out_data_q <= r_shift[WIDTH-1:0];
                        out_sat_q  <= 1'b0;
                    end
                end
                S_OUT: begin
                    // out_data stays in the register after the handshake; only out_valid qualifies it
                    if (bus.out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
endmodule

// File: tb/tb_signed_fix_point_acc_requant.sv
// Bench for the dot-product requantiser: directed vector table, reset abort, then random dot
// products checked against an arithmetic reference model.
module tb_signed_fix_point_acc_requant;
    localparam int WIDTH = 32;
    localparam int PW    = 16;
    localparam int LW    = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    signed_fix_point_acc_requant_if #(.WIDTH(WIDTH), .LEN_WIDTH(LW)) bus ();

    signed_fix_point_acc_requant #(.WIDTH(WIDTH), .POINT_WIDTH(PW), .GUARD(8), .LEN_WIDTH(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] prod_buf [0:15];

    typedef struct {
        int          len;
        logic [63:0] prod;
        logic [31:0] exp_data;
        bit          exp_sat;
        int          gap_pct;
        int          stall;
        bit          pulse;
    } vec_t;

    vec_t vecs [0:8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact sum of the terms, floor((sum + half LSB) / 2^PW), clipped to WIDTH bits.
    function automatic void model(input int n, output logic [31:0] d, output bit s);
        logic signed [71:0] sum;
        logic signed [71:0] r;
        sum = '0;
        for (int i = 0; i < n; i++) sum = sum + 72'($signed(prod_buf[i]));
        r = (sum + 72'sd32768) >>> PW;
        if (r > 72'sd2147483647) begin
            d = 32'h7FFF_FFFF; s = 1'b1;
        end else if (r < -72'sd2147483648) begin
            d = 32'h8000_0000; s = 1'b1;
        end else begin
            d = r[31:0]; s = 1'b0;
        end
    endfunction

    task automatic run_dot(input string name, input int n, input logic [31:0] exp_d, input bit exp_s,
                           input int gap_pct, input int stall, input bit pulse);
        int sent;
        int cyc;
        bit v;
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = LW'(n);
        @(negedge clk);
        bus.start = 1'b0;
        check({name, "_busy"}, 64'(bus.busy), 64'd1);
        if (n > 0) check({name, "_in_ready_on"}, 64'(bus.in_ready), 64'd1);
        sent = 0;
        cyc  = 0;
        while (sent < n && cyc < n*20 + 50) begin
            v = ($urandom_range(99) >= gap_pct);
            bus.in_valid = v;
            bus.in_prod  = v ? prod_buf[sent] : {$urandom, $urandom};
            bus.start    = pulse && (cyc == 2);
            bus.len      = LW'(9);
            if (bus.in_ready !== 1'b1) check({name, "_in_ready_acc"}, 64'(bus.in_ready), 64'd1);
            @(negedge clk);
            if (v) sent++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        if (sent < n) check({name, "_beat_timeout"}, 64'(sent), 64'(n));
        check({name, "_round_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({name, "_round_in_ready"}, 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        check({name, "_out_valid"}, 64'(bus.out_valid), 64'd1);
        check({name, "_data"}, 64'(bus.out_data), 64'(exp_d));
        check({name, "_sat"}, 64'(bus.out_sat), 64'(exp_s));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({name, "_stall_valid"}, 64'(bus.out_valid), 64'd1);
            check({name, "_stall_data"}, {31'd0, bus.out_sat, bus.out_data}, {31'd0, exp_s, exp_d});
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({name, "_done_busy"}, 64'(bus.busy), 64'd0);
        check({name, "_done_valid"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        logic [31:0] ed;
        bit          es;
        int          n;
        bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0; bus.in_prod = '0; bus.out_ready = 1'b0;

        vecs[0] = '{3, 64'h0000_0001_0000_0000, 32'h0003_0000, 1'b0, 0,  4, 1'b0};
        vecs[1] = '{1, 64'h0000_0000_0000_8000, 32'h0000_0001, 1'b0, 0,  0, 1'b0};
        vecs[2] = '{1, 64'hFFFF_FFFF_FFFF_8000, 32'h0000_0000, 1'b0, 0,  1, 1'b0};
        vecs[3] = '{1, 64'h0000_0000_0000_7FFF, 32'h0000_0000, 1'b0, 0,  0, 1'b0};
        vecs[4] = '{2, 64'h0000_7FFF_0000_0000, 32'h7FFF_FFFF, 1'b1, 0,  2, 1'b0};
        vecs[5] = '{2, 64'hFFFF_8000_0000_0000, 32'h8000_0000, 1'b1, 0,  0, 1'b0};
        vecs[6] = '{1, 64'hFFFF_8000_0000_0000, 32'h8000_0000, 1'b0, 0,  0, 1'b0};
        vecs[7] = '{0, 64'h0,                   32'h0000_0000, 1'b0, 0,  1, 1'b0};
        vecs[8] = '{4, 64'h0000_0002_0000_0000, 32'h0008_0000, 1'b0, 40, 0, 1'b1};

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_sat", 64'(bus.out_sat), 64'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < 16; i++) prod_buf[i] = vecs[k].prod;
            run_dot($sformatf("vec%0d", k), vecs[k].len, vecs[k].exp_data, vecs[k].exp_sat,
                    vecs[k].gap_pct, vecs[k].stall, vecs[k].pulse);
        end

        // Abort a 5-term sum after 2 beats; a fresh 1-term sum must show no residue.
        @(negedge clk);
        bus.start = 1'b1; bus.len = LW'(5);
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_valid = 1'b1; bus.in_prod = 64'h0000_0003_0000_0000;
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_in_ready", 64'(bus.in_ready), 64'd0);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_out_data", 64'(bus.out_data), 64'd0);
        check("abort_out_sat", 64'(bus.out_sat), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prod_buf[0] = 64'h0000_0001_0000_0000;
        run_dot("after_abort", 1, 32'h0001_0000, 1'b0, 0, 0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            n = $urandom_range(0, 12);
            for (int i = 0; i < 16; i++) begin
                case ($urandom_range(2))
                    0:       prod_buf[i] = {$urandom, $urandom};
                    1:       prod_buf[i] = 64'($signed($urandom));
                    default: prod_buf[i] = 64'($signed($urandom)) <<< $urandom_range(0, 20);
                endcase
            end
            model(n, ed, es);
            run_dot($sformatf("rand%0d", k), n, ed, es, 30, $urandom_range(0, 3), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/signed_fix_point_acc_requant.md
# signed_fix_point_acc_requant

Consumes the double-width signed fixed-point products from the multiplier (Q(2·(WIDTH−POINT_WIDTH)).(2·POINT_WIDTH), 2·WIDTH bits) and reduces them back to the WIDTH-bit working format. It accumulates a programmed number of products into a dot-product sum, rounds and shifts away POINT_WIDTH fraction bits, and saturates. It returns one WIDTH-bit result per dot product over a valid/ready handshake. It sits between the multiplier array and the CNN layer writeback path.

## Interface
- WIDTH, 32, working data width (signed, Q(WIDTH−POINT_WIDTH).POINT_WIDTH)
- POINT_WIDTH, 16, fraction bits of the working format; must satisfy 1 ≤ POINT_WIDTH < WIDTH
- GUARD, 8, extra accumulator headroom bits; accumulator width is 2·WIDTH+GUARD
- LEN_WIDTH, 16, width of the term-count input

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a dot product; honoured only in IDLE
- len  in  LEN_WIDTH  number of products to accumulate, unsigned; sampled when start is honoured
- busy  out  1  high in every state except IDLE
- in_valid  in  1  product beat valid
- in_ready  out  1  block accepts a product this cycle
- in_prod  in  2·WIDTH  signed product, 2·POINT_WIDTH fraction bits
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  WIDTH  signed result, POINT_WIDTH fraction bits
- out_sat  out  1  result was clipped; qualified by out_valid

## Operation
- States: IDLE, ACC, ROUND, OUT.
- IDLE: when start=1, clear the accumulator and latch len into the remaining-term counter. If len≠0, go to ACC. If len=0, go to ROUND, which yields result 0 with out_sat=0.
- ACC: in_ready=1. On in_valid && in_ready, acc ← acc + sign-extended in_prod, and decrement the counter. On the beat that takes the counter to 0, go to ROUND.
- ROUND: compute r = (acc + 2^(POINT_WIDTH−1)) >>> POINT_WIDTH.
  - The shift is arithmetic.
  - Rounding is round-half-up, toward +∞.
  - Then go to OUT.
- Saturation:
  - If r > 2^(WIDTH−1)−1, out_data = 0x7FFF…F and out_sat=1.
  - If r < −2^(WIDTH−1), out_data = 0x800…0 and out_sat=1.
  - Otherwise out_data = r[WIDTH−1:0] and out_sat=0.
  - The result is registered at the end of ROUND.
- OUT: out_valid=1. out_data and out_sat are held stable until out_valid && out_ready, then go to IDLE.
- start is ignored outside IDLE. in_ready=0 outside ACC, and in_valid is ignored there.
- Accumulator overflow beyond 2·WIDTH+GUARD bits wraps two's-complement. The guard bits cover 2^GUARD terms of full-scale products without wrap.
- Reset (any time, including mid-accumulation or while OUT is stalled):
  - State goes to IDLE, and the accumulator and counter clear.
  - The partial result is discarded, with no output beat.

## Timing
- Reset values: busy=0, in_ready=0, out_valid=0, out_data=0, out_sat=0.
- start honoured at cycle t: busy=1 and in_ready=1 from t+1 (len≠0).
- At most one product is accepted per cycle. Full throughput: len products are taken in len consecutive cycles when in_valid is held high.
- Last product accepted at cycle t: ROUND at t+1, out_valid=1 from t+2.
- Back-to-back dot products: after the output handshake at cycle u, IDLE at u+1, so the earliest next start is at u+1.
- len=0: start at t gives out_valid at t+2 with out_data=0.
- Gaps in in_valid stall the accumulation without corrupting the sum or the counter.

## Test plan
- Accumulate and backpressure:
  - Stimulus: start, len=3, three beats of 0x0000_0001_0000_0000 (1.0). Hold out_ready=0 for 4 cycles after out_valid, then assert it.
  - Response: out_data=0x0003_0000, out_sat=0, and out_valid=1 two cycles after the last beat. out_data stays stable through the stall, then busy drops.
- Rounding:
  - len=1 with in_prod=0x0000_0000_0000_8000 → 0x0000_0001.
  - len=1 with in_prod=0xFFFF_FFFF_FFFF_8000 → 0x0000_0000.
  - len=1 with in_prod=0x0000_0000_0000_7FFF → 0x0000_0000.
- Saturation:
  - Two beats of 0x0000_7FFF_0000_0000 → out_data=0x7FFF_FFFF, out_sat=1.
  - Two beats of 0xFFFF_8000_0000_0000 → out_data=0x8000_0000, out_sat=1.
  - One beat of 0xFFFF_8000_0000_0000 → out_data=0x8000_0000, out_sat=0.
- Gapped input and ignored start:
  - Stimulus: len=4, beats of 2.0 each with random in_valid gaps, and start pulsed during ACC.
  - Response: exactly 4 beats consumed, out_data=0x0008_0000, and the extra start has no effect.
- len=0: start with len=0 → out_valid two cycles later, out_data=0, out_sat=0, and in_ready never asserted.
- Reset mid-operation:
  - Assert rst_n=0 after 2 of 5 beats, then release.
  - All outputs return to their reset values immediately.
  - A new start with len=1 and 1.0 yields 0x0001_0000, with no residue from the aborted sum.
